// File: rtl/vector_fetch_unit.sv
// vector_fetch_unit
//   Datapath-side responder to vector-fetch requests. Each request reads the
//   reset/interrupt/reserved vector slot (VEC_BASE + 2*fetch_src) from
//   instruction memory over a req/ack port, assembles a 16-bit (one word) or
//   32-bit (two words, high word first) target and loads it into the PC with
//   a one-cycle pc_we strobe. busy stalls the front end while a sequence is
//   in flight or a request is pending.
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   fetch           request level; a rising level (vs. registered copy) is an event
//   extend          1 = 32-bit vector, 0 = 16-bit vector
//   fetch_src       vector slot select (00 reset, 01 interrupt, 10/11 reserved)
//   mem_req/mem_addr/mem_rdata/mem_ack   instruction-memory read port
//   pc_we, pc_next  PC load strobe and value (value held after the strobe)
//   busy            sequence in progress or request pending
//   err             timeout abort pulse
//
// Configuration
//   VECTOR_TIMEOUT_EN  when defined, a read that waits TIMEOUT consecutive
//                      request cycles without mem_ack is aborted (err pulse,
//                      no PC load). When undefined, reads wait indefinitely
//                      and err is tied low.

module vector_fetch_unit #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned VEC_BASE = 0,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch,
  input  logic              extend,
  input  logic [1:0]        fetch_src,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              pc_we,
  output logic [31:0]       pc_next,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_HI = 2'd1,
    RD_LO = 2'd2,
    LOAD  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(VEC_BASE);

  state_t              state_q, state_d;
  logic                fetch_d_q;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         hi_q, hi_d;
  logic [31:0]         pc_next_q, pc_next_d;
  logic [1:0]          req_src_q, req_src_d;
  logic                req_ext_q, req_ext_d;
  logic                pend_v_q, pend_v_d;
  logic [1:0]          pend_src_q, pend_src_d;
  logic                pend_ext_q, pend_ext_d;

  logic                req_event;
  logic                preempt;

`ifdef VECTOR_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;

  assign err = err_q;
`else
  logic                unused_timeout;

  assign unused_timeout = (TIMEOUT != 0);
  assign err            = 1'b0;
`endif

  // Only a rising request level is an event; fetch_d_q resets low so a
  // request already high when reset releases still counts.
  assign req_event = fetch & ~fetch_d_q;
  assign preempt   = req_event & (fetch_src == 2'b00);

  assign mem_req  = (state_q == RD_HI) || (state_q == RD_LO);
  assign mem_addr = addr_q;
  assign pc_we    = (state_q == LOAD);
  assign pc_next  = pc_next_q;
  assign busy     = (state_q != IDLE) || pend_v_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    hi_d       = hi_q;
    pc_next_d  = pc_next_q;
    req_src_d  = req_src_q;
    req_ext_d  = req_ext_q;
    pend_v_d   = pend_v_q;
    pend_src_d = pend_src_q;
    pend_ext_d = pend_ext_q;
`ifdef VECTOR_TIMEOUT_EN
    cnt_d      = cnt_q;
    err_d      = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        // A fresh event takes priority over (and discards) a pending one.
        if (req_event || pend_v_q) begin
          req_src_d = req_event ? fetch_src : pend_src_q;
          req_ext_d = req_event ? extend    : pend_ext_q;
          pend_v_d  = 1'b0;
          addr_d    = BASE_ADDR + ADDR_W'({req_src_d, 1'b0});
          state_d   = req_ext_d ? RD_HI : RD_LO;
`ifdef VECTOR_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end
      end

      RD_HI, RD_LO: begin
        // Any event while busy is parked in the pending slot. A reset-vector
        // event also abandons the current read: going through IDLE drops
        // mem_req for one cycle and the pending slot restarts the sequence.
        if (req_event) begin
          pend_v_d   = 1'b1;
          pend_src_d = fetch_src;
          pend_ext_d = extend;
        end
        if (preempt) begin
          state_d = IDLE;
        end else if (mem_ack) begin
          if (state_q == RD_HI) begin
            hi_d    = mem_rdata;
            addr_d  = addr_q + ADDR_W'(1);
            state_d = RD_LO;
          end else begin
            pc_next_d = req_ext_q ? {hi_q, mem_rdata} : {16'h0000, mem_rdata};
            state_d   = LOAD;
          end
`ifdef VECTOR_TIMEOUT_EN
          cnt_d = '0;
`endif
        end else begin
`ifdef VECTOR_TIMEOUT_EN
          if (cnt_q == TO_LAST) begin
            state_d = IDLE;
            err_d   = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
`endif
        end
      end

      LOAD: begin
        // The load strobe always completes; an event here waits in pending.
        state_d = IDLE;
        if (req_event) begin
          pend_v_d   = 1'b1;
          pend_src_d = fetch_src;
          pend_ext_d = extend;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      fetch_d_q  <= 1'b0;
      addr_q     <= '0;
      hi_q       <= '0;
      pc_next_q  <= '0;
      req_src_q  <= '0;
      req_ext_q  <= 1'b0;
      pend_v_q   <= 1'b0;
      pend_src_q <= '0;
      pend_ext_q <= 1'b0;
`ifdef VECTOR_TIMEOUT_EN
      cnt_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      fetch_d_q  <= fetch;
      addr_q     <= addr_d;
      hi_q       <= hi_d;
      pc_next_q  <= pc_next_d;
      req_src_q  <= req_src_d;
      req_ext_q  <= req_ext_d;
      pend_v_q   <= pend_v_d;
      pend_src_q <= pend_src_d;
      pend_ext_q <= pend_ext_d;
`ifdef VECTOR_TIMEOUT_EN
      cnt_q      <= cnt_d;
      err_q      <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_vector_fetch_unit.sv
// Self-checking bench for vector_fetch_unit: reset values, a table of fixed
// requests, multi-cycle corner sequences (held level, reset preemption,
// pending service, address wrap, timeout) and randomized requests checked
// against a slot/word-level reference model.

module tb_vector_fetch_unit;

  localparam int unsigned AW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          fetch;
  logic          extend;
  logic [1:0]    fetch_src;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic          pc_we;
  logic [31:0]   pc_next;
  logic          busy;
  logic          err;

  // Second instance with the vector base at the top of the address space,
  // fed by an always-ready memory, to exercise address wrap.
  logic          mem_req2;
  logic [AW-1:0] mem_addr2;
  logic [15:0]   mem_rdata2;
  logic          mem_ack2;
  logic          pc_we2;
  logic [31:0]   pc_next2;
  logic          busy2;
  logic          err2;

  vector_fetch_unit #(.ADDR_W(AW), .VEC_BASE(0), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .fetch(fetch), .extend(extend), .fetch_src(fetch_src),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .pc_we(pc_we), .pc_next(pc_next), .busy(busy), .err(err)
  );

  vector_fetch_unit #(.ADDR_W(AW), .VEC_BASE(16'hFFFF), .TIMEOUT(15)) dut_wrap (
    .clk(clk), .rst(rst), .fetch(fetch), .extend(extend), .fetch_src(fetch_src),
    .mem_req(mem_req2), .mem_addr(mem_addr2), .mem_rdata(mem_rdata2), .mem_ack(mem_ack2),
    .pc_we(pc_we2), .pc_next(pc_next2), .busy(busy2), .err(err2)
  );

  assign mem_ack2   = mem_req2;
  assign mem_rdata2 = mem_addr2 ^ 16'h5A5A;

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model: answers after wait_cfg request cycles with mem[addr].
  logic [15:0]   mem [0:255];
  int            wait_cfg  = 0;
  bit            never_ack = 1'b0;
  int            wcnt      = 0;
  logic [AW-1:0] reads [$];
  logic          prev_req  = 1'b0;
  logic          prev_ack  = 1'b0;
  logic [AW-1:0] prev_addr = '0;

  always @(negedge clk) begin
    if (rst && mem_req && prev_req && !prev_ack)
      check("addr_stable", 32'(mem_addr), 32'(prev_addr));
    prev_req  = mem_req;
    prev_addr = mem_addr;
    if (!rst || !mem_req || never_ack) begin
      mem_ack = 1'b0;
      wcnt    = 0;
    end else if (wcnt >= wait_cfg) begin
      mem_ack   = 1'b1;
      mem_rdata = mem[mem_addr[7:0]];
      reads.push_back(mem_addr);
      wcnt      = 0;
    end else begin
      mem_ack = 1'b0;
      wcnt++;
    end
    prev_ack = mem_ack;
  end

  // Per-run observations, indexed by cycle offset from the request event.
  int            r_nwe, r_lat, r_we_at, r_errs, r_err_at, r_req_cnt;
  logic [31:0]   r_val [2];
  logic          r_busy_after, r_busy_end, r_req_end;
  logic          rq [0:63];
  logic          bz [0:63];
  logic [AW-1:0] ad [0:63];

  task automatic run_req(input logic [1:0] s, input logic e, input int w, input bit hold,
                         input int ncyc, input int inj_at, input logic [1:0] inj_s,
                         input logic inj_e);
    @(negedge clk);
    wait_cfg = w;
    reads.delete();
    r_nwe = 0; r_lat = -1; r_we_at = -1; r_errs = 0; r_err_at = -1; r_req_cnt = 0;
    r_val[0] = '0; r_val[1] = '0; r_busy_after = 1'bx;
    fetch = 1'b1; fetch_src = s; extend = e;
    rst = 1'b1;
    for (int i = 1; i <= ncyc; i++) begin
      @(negedge clk);
      if (pc_we) begin
        if (r_nwe < 2) r_val[r_nwe] = pc_next;
        if (r_nwe == 0) begin r_lat = i; r_we_at = i; end
        r_nwe++;
      end
      if (r_we_at >= 0 && i == r_we_at + 1) r_busy_after = busy;
      if (err) begin
        r_errs++;
        if (r_err_at < 0) r_err_at = i;
      end
      if (mem_req) r_req_cnt++;
      if (i < 64) begin rq[i] = mem_req; bz[i] = busy; ad[i] = mem_addr; end
      r_busy_end = busy;
      r_req_end  = mem_req;
      if (!hold) fetch = 1'b0;
      if (inj_at > 0 && i == inj_at) begin
        fetch = 1'b1; fetch_src = inj_s; extend = inj_e;
      end
    end
    fetch = 1'b0;
  endtask

  task automatic check_reads(input string name, input int start, input int n);
    check({name, "_nreads"}, reads.size(), n);
    for (int k = 0; k < n && k < reads.size(); k++)
      check({name, "_raddr"}, 32'(reads[k]), 32'(AW'(start + k)));
  endtask

  typedef struct {
    logic [1:0]  src;
    logic        ext;
    int          w;
    logic [31:0] pc;
    int          lat;
  } vec_t;

  vec_t tbl [6];

  initial begin
    logic [1:0]  rs;
    logic        re;
    int          rw;
    logic [31:0] rexp;

    mem[0] = 16'h1234; mem[1] = 16'h5678; mem[2] = 16'hBEEF; mem[3] = 16'hCAFE;
    mem[4] = 16'hA5A5; mem[5] = 16'h0F0F; mem[6] = 16'hDEAD; mem[7] = 16'h0001;
    for (int k = 8; k < 256; k++) mem[k] = 16'(k);

    tbl[0] = '{2'd0, 1'b1, 0, 32'h12345678, 3};
    tbl[1] = '{2'd1, 1'b0, 2, 32'h0000BEEF, 4};
    tbl[2] = '{2'd1, 1'b1, 1, 32'hBEEFCAFE, 5};
    tbl[3] = '{2'd2, 1'b0, 0, 32'h0000A5A5, 2};
    tbl[4] = '{2'd3, 1'b1, 3, 32'hDEAD0001, 9};
    tbl[5] = '{2'd2, 1'b1, 0, 32'hA5A50F0F, 3};

    // Reset values, with a request already high during reset.
    rst = 1'b0; fetch = 1'b1; extend = 1'b1; fetch_src = 2'b00;
    repeat (3) @(negedge clk);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_pc_we", 32'(pc_we), 32'd0);
    check("rst_pc_next", pc_next, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);

    // Request high out of reset counts as an event.
    run_req(2'd0, 1'b1, 0, 1'b0, 30, -1, 2'd0, 1'b0);
    check("por_pc", r_val[0], 32'h12345678);
    check("por_lat", r_lat, 3);
    check("por_nwe", r_nwe, 1);
    check("por_busy_after", 32'(r_busy_after), 32'd0);
    check_reads("por", 0, 2);
    check("wrap_pc", pc_next2, 32'hA5A55A5A);

    // Table of single requests with fixed memory contents.
    for (int t = 0; t < 6; t++) begin
      run_req(tbl[t].src, tbl[t].ext, tbl[t].w, 1'b0, 30, -1, 2'd0, 1'b0);
      check("tbl_pc", r_val[0], tbl[t].pc);
      check("tbl_lat", r_lat, tbl[t].lat);
      check("tbl_nwe", r_nwe, 1);
      check("tbl_busy_after", 32'(r_busy_after), 32'd0);
      check_reads("tbl", 2 * int'(tbl[t].src), tbl[t].ext ? 2 : 1);
    end

    // Level held high does not retrigger.
    run_req(2'd2, 1'b0, 1, 1'b1, 30, -1, 2'd0, 1'b0);
    check("hold_nwe", r_nwe, 1);
    check("hold_pc", r_val[0], 32'h0000A5A5);

    // Interrupt in RD_HI preempted by a reset-vector event.
    run_req(2'd1, 1'b1, 3, 1'b0, 30, 2, 2'd0, 1'b1);
    check("pre_req_drop", 32'(rq[3]), 32'd0);
    check("pre_busy_drop", 32'(bz[3]), 32'd1);
    check("pre_req_restart", 32'(rq[4]), 32'd1);
    check("pre_addr_restart", 32'(ad[4]), 32'd0);
    check("pre_nwe", r_nwe, 1);
    check("pre_pc", r_val[0], 32'h12345678);
    check_reads("pre", 0, 2);

    // Interrupt event during a reset-vector sequence waits in pending.
    run_req(2'd0, 1'b1, 1, 1'b0, 30, 2, 2'd1, 1'b0);
    check("pend_nwe", r_nwe, 2);
    check("pend_pc0", r_val[0], 32'h12345678);
    check("pend_pc1", r_val[1], 32'h0000BEEF);
    check("pend_busy_between", 32'(bz[6]), 32'd1);
    check("pend_busy_end", 32'(r_busy_end), 32'd0);
    check_reads("pend", 0, 3);

    // Randomized requests against the slot/word model.
    for (int k = 0; k < 60; k++) begin
      for (int m = 0; m < 8; m++) mem[m] = 16'($urandom);
      rs = 2'($urandom_range(0, 3));
      re = 1'($urandom_range(0, 1));
      rw = int'($urandom_range(0, 3));
      rexp = re ? {mem[2 * int'(rs)], mem[2 * int'(rs) + 1]} : {16'h0000, mem[2 * int'(rs)]};
      run_req(rs, re, rw, 1'b0, 20, -1, 2'd0, 1'b0);
      check("rnd_pc", r_val[0], rexp);
      check("rnd_lat", r_lat, re ? 3 + 2 * rw : 2 + rw);
      check("rnd_nwe", r_nwe, 1);
      check_reads("rnd", 2 * int'(rs), re ? 2 : 1);
    end

    // Memory that never acknowledges.
    never_ack = 1'b1;
    run_req(2'd1, 1'b0, 0, 1'b0, 40, -1, 2'd0, 1'b0);
    check("to_nwe", r_nwe, 0);
`ifdef VECTOR_TIMEOUT_EN
    check("to_req_cycles", r_req_cnt, 15);
    check("to_errs", r_errs, 1);
    check("to_err_at", r_err_at, 16);
    check("to_busy_end", 32'(r_busy_end), 32'd0);
    check("to_req_end", 32'(r_req_end), 32'd0);
`else
    check("to_req_cycles", r_req_cnt, 40);
    check("to_errs", r_errs, 0);
    check("to_busy_end", 32'(r_busy_end), 32'd1);
    check("to_req_end", 32'(r_req_end), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
